// File: rtl/pkt_flow_stat.sv
// rtl/pkt_flow_stat.sv - per-flow L1/L2 byte and packet meter with windowed snapshots (optional macro PKT_FLOW_STAT_ERR_CNT_EN)
module pkt_flow_stat #(
    parameter int D_WIDTH      = 64,
    parameter int EMPTY_WIDTH  = 3,
    parameter int FLOW_CNT     = 16,
    parameter int FLOW_W       = 4,
    parameter int WINDOW_TICKS = 156250,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sop_i,
    input  logic                   eop_i,
    input  logic [EMPTY_WIDTH-1:0] empty_i,
    input  logic                   val_i,
    input  logic [FLOW_W-1:0]      flow_num_i,
    input  logic                   clear_i,
    input  logic [FLOW_W-1:0]      rd_flow_i,
    output logic [CNT_W-1:0]       rd_l1_bytes_o,
    output logic [CNT_W-1:0]       rd_l2_bytes_o,
    output logic [CNT_W-1:0]       rd_pkts_o,
    output logic                   window_done_o,
    output logic                   proto_err_o,
    output logic [15:0]            err_cnt_o
);

    localparam int BYTES = D_WIDTH / 8;
    localparam int WIN_W = $clog2(WINDOW_TICKS);
    // 12 bytes inter-frame gap plus 8 bytes preamble/SFD per packet
    localparam int L1_OVERHEAD = 20;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    typedef logic [CNT_W-1:0] cnt_t;

    logic [0:0]        state, nxt_state;
    logic [FLOW_W-1:0] cur_flow, nxt_flow;
    logic              cur_vld, nxt_vld;
    logic              byte_en, close_en, err, new_ok, win_end;
    logic [FLOW_W-1:0] byte_flow;
    logic [WIN_W-1:0]  win_cnt;
    cnt_t              beat_l2, beat_l1;

    cnt_t acc_l1  [FLOW_CNT];
    cnt_t acc_l2  [FLOW_CNT];
    cnt_t acc_pk  [FLOW_CNT];
    cnt_t nxt_l1  [FLOW_CNT];
    cnt_t nxt_l2  [FLOW_CNT];
    cnt_t nxt_pk  [FLOW_CNT];
    cnt_t snap_l1 [FLOW_CNT];
    cnt_t snap_l2 [FLOW_CNT];
    cnt_t snap_pk [FLOW_CNT];

    function automatic cnt_t sat_add(input cnt_t a, input cnt_t b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign new_ok  = 32'(flow_num_i) < FLOW_CNT;
    assign win_end = (win_cnt == WIN_W'(WINDOW_TICKS - 1));

    // Byte weight of the current beat; empty only matters on the eop beat
    always_comb begin
        beat_l2 = CNT_W'(BYTES) - (eop_i ? CNT_W'(empty_i) : '0);
        beat_l1 = beat_l2 + (eop_i ? CNT_W'(L1_OVERHEAD) : '0);
    end

    // Framing decode: which flow earns this beat, whether an open packet is force-closed, and errors
    always_comb begin
        nxt_state = state;
        nxt_flow  = cur_flow;
        nxt_vld   = cur_vld;
        byte_en   = 1'b0;
        byte_flow = cur_flow;
        close_en  = 1'b0;
        err       = 1'b0;
        if (val_i) begin
            if (sop_i) begin
                // A sop inside a packet closes the old one (no overhead) and starts a new one
                err       = (state == ST_IN_PKT) || !new_ok;
                close_en  = (state == ST_IN_PKT) && cur_vld;
                byte_en   = new_ok;
                byte_flow = flow_num_i;
                nxt_flow  = flow_num_i;
                nxt_vld   = new_ok;
                nxt_state = eop_i ? ST_IDLE : ST_IN_PKT;
            end else if (state == ST_IN_PKT) begin
                byte_en = cur_vld;
                if (eop_i) begin
                    nxt_state = ST_IDLE;
                end
            end else begin
                // Stray beat outside a packet is discarded
                err = 1'b1;
            end
        end
    end

    // Per-flow accumulator plus this cycle's contribution, saturating
    always_comb begin
        for (int f = 0; f < FLOW_CNT; f++) begin
            logic hit_b;
            logic hit_c;
            hit_b     = byte_en && (32'(byte_flow) == f);
            hit_c     = close_en && (32'(cur_flow) == f);
            nxt_l2[f] = sat_add(acc_l2[f], hit_b ? beat_l2 : '0);
            nxt_l1[f] = sat_add(acc_l1[f], hit_b ? beat_l1 : '0);
            nxt_pk[f] = sat_add(acc_pk[f], CNT_W'(hit_b && eop_i) + CNT_W'(hit_c));
        end
    end

    // Framing state and latched flow of the open packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur_flow <= '0;
            cur_vld  <= 1'b0;
        end else if (clear_i) begin
            state    <= ST_IDLE;
            cur_flow <= '0;
            cur_vld  <= 1'b0;
        end else begin
            state    <= nxt_state;
            cur_flow <= nxt_flow;
            cur_vld  <= nxt_vld;
        end
    end

    // Measurement window counter, wraps at WINDOW_TICKS-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
        end else if (clear_i || win_end) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + WIN_W'(1);
        end
    end

    // Accumulate; at window end copy totals (including this cycle) to snapshots and restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < FLOW_CNT; f++) begin
                acc_l1[f]  <= '0;
                acc_l2[f]  <= '0;
                acc_pk[f]  <= '0;
                snap_l1[f] <= '0;
                snap_l2[f] <= '0;
                snap_pk[f] <= '0;
            end
        end else if (clear_i) begin
            for (int f = 0; f < FLOW_CNT; f++) begin
                acc_l1[f]  <= '0;
                acc_l2[f]  <= '0;
                acc_pk[f]  <= '0;
                snap_l1[f] <= '0;
                snap_l2[f] <= '0;
                snap_pk[f] <= '0;
            end
        end else if (win_end) begin
            for (int f = 0; f < FLOW_CNT; f++) begin
                acc_l1[f]  <= '0;
                acc_l2[f]  <= '0;
                acc_pk[f]  <= '0;
                snap_l1[f] <= nxt_l1[f];
                snap_l2[f] <= nxt_l2[f];
                snap_pk[f] <= nxt_pk[f];
            end
        end else begin
            for (int f = 0; f < FLOW_CNT; f++) begin
                acc_l1[f] <= nxt_l1[f];
                acc_l2[f] <= nxt_l2[f];
                acc_pk[f] <= nxt_pk[f];
            end
        end
    end

    // One-cycle pulse marking fresh snapshots; suppressed by a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_done_o <= 1'b0;
        end else begin
            window_done_o <= win_end && !clear_i;
        end
    end

    // Registered snapshot read; out-of-range index reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_l1_bytes_o <= '0;
            rd_l2_bytes_o <= '0;
            rd_pkts_o     <= '0;
        end else if (clear_i || !(32'(rd_flow_i) < FLOW_CNT)) begin
            rd_l1_bytes_o <= '0;
            rd_l2_bytes_o <= '0;
            rd_pkts_o     <= '0;
        end else begin
            rd_l1_bytes_o <= snap_l1[rd_flow_i];
            rd_l2_bytes_o <= snap_l2[rd_flow_i];
            rd_pkts_o     <= snap_pk[rd_flow_i];
        end
    end

    // Sticky framing error flag, survives clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_o <= 1'b0;
        end else if (err) begin
            proto_err_o <= 1'b1;
        end
    end

`ifdef PKT_FLOW_STAT_ERR_CNT_EN
    logic [15:0] err_cnt;

    // Saturating framing error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clear_i) begin
            err_cnt <= '0;
        end else if (err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pkt_flow_stat.sv
// tb/tb_pkt_flow_stat.sv - self-checking bench for pkt_flow_stat
module tb_pkt_flow_stat;

    localparam int WT = 1000;
`ifdef PKT_FLOW_STAT_ERR_CNT_EN
    localparam bit ERRC = 1'b1;
`else
    localparam bit ERRC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sop_i = 1'b0;
    logic        eop_i = 1'b0;
    logic [2:0]  empty_i = '0;
    logic        val_i = 1'b0;
    logic [3:0]  flow_num_i = '0;
    logic        clear_i = 1'b0;
    logic [3:0]  rd_flow_i = '0;
    logic [31:0] rd_l1, rd_l2, rd_pk;
    logic        done, perr;
    logic [15:0] ecnt;
    logic [7:0]  s_l1, s_l2, s_pk;
    logic        s_done, s_perr;
    logic [15:0] s_ecnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pkt_flow_stat #(.WINDOW_TICKS(WT), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .sop_i(sop_i), .eop_i(eop_i), .empty_i(empty_i),
        .val_i(val_i), .flow_num_i(flow_num_i), .clear_i(clear_i), .rd_flow_i(rd_flow_i),
        .rd_l1_bytes_o(rd_l1), .rd_l2_bytes_o(rd_l2), .rd_pkts_o(rd_pk),
        .window_done_o(done), .proto_err_o(perr), .err_cnt_o(ecnt)
    );

    pkt_flow_stat #(.WINDOW_TICKS(WT), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .sop_i(sop_i), .eop_i(eop_i), .empty_i(empty_i),
        .val_i(val_i), .flow_num_i(flow_num_i), .clear_i(clear_i), .rd_flow_i(rd_flow_i),
        .rd_l1_bytes_o(s_l1), .rd_l2_bytes_o(s_l2), .rd_pkts_o(s_pk),
        .window_done_o(s_done), .proto_err_o(s_perr), .err_cnt_o(s_ecnt)
    );

    typedef struct {
        int flow; int len; int n;
        int l2; int l1; int pk;
        int l2s; int l1s; int pks;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < WT + 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL window_done_timeout got 0 expected 1");
        end
    endtask

    task automatic send_pkt(input int flow, input int len);
        int beats;
        beats = (len + 7) / 8;
        for (int b = 0; b < beats; b++) begin
            val_i      = 1'b1;
            sop_i      = (b == 0);
            eop_i      = (b == beats - 1);
            empty_i    = (b == beats - 1) ? 3'(beats * 8 - len) : 3'd0;
            flow_num_i = 4'(flow);
            @(negedge clk);
        end
        val_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; empty_i = '0;
    endtask

    task automatic beat(input logic s, input logic e, input int flow);
        val_i = 1'b1; sop_i = s; eop_i = e; empty_i = '0; flow_num_i = 4'(flow);
        @(negedge clk);
        val_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    endtask

    task automatic rd3(input string name, input int flow, input int l2, input int l1, input int pk);
        rd_flow_i = 4'(flow);
        @(negedge clk);
        chk({name, "_l2"}, rd_l2, 32'(l2));
        chk({name, "_l1"}, rd_l1, 32'(l1));
        chk({name, "_pkts"}, rd_pk, 32'(pk));
    endtask

    initial begin
        vecs[0] = '{3, 64, 1, 64, 84, 1, 64, 84, 1};
        vecs[1] = '{0, 65, 50, 3250, 4250, 50, 255, 255, 50};
        vecs[2] = '{15, 1, 3, 3, 63, 3, 3, 63, 3};
        vecs[3] = '{7, 100, 2, 200, 240, 2, 200, 240, 2};

        repeat (3) @(negedge clk);
        chk("reset_rd_l2", rd_l2, 0);
        chk("reset_rd_pkts", rd_pk, 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_proto_err", 32'(perr), 0);
        chk("reset_err_cnt", 32'(ecnt), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            wait_done();
            for (int p = 0; p < vecs[i].n; p++) send_pkt(vecs[i].flow, vecs[i].len);
            wait_done();
            rd_flow_i = 4'(vecs[i].flow);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 0);
            chk("vec_l2", rd_l2, 32'(vecs[i].l2));
            chk("vec_l1", rd_l1, 32'(vecs[i].l1));
            chk("vec_pkts", rd_pk, 32'(vecs[i].pk));
            chk("vec8_l2", 32'(s_l2), 32'(vecs[i].l2s));
            chk("vec8_l1", 32'(s_l1), 32'(vecs[i].l1s));
            chk("vec8_pkts", 32'(s_pk), 32'(vecs[i].pks));
            rd3("vec_other", (vecs[i].flow + 1) % 16, 0, 0, 0);
        end
        chk("no_err_yet", 32'(perr), 0);

        // Packet straddling the window boundary: 4 beats before, 4 beats after
        wait_done();
        repeat (996) @(negedge clk);
        send_pkt(5, 64);
        rd3("straddle_a", 5, 32, 32, 0);
        wait_done();
        rd3("straddle_b", 5, 32, 52, 1);

        // Stray beat in IDLE, then sop inside an open packet
        beat(1'b0, 1'b0, 2);
        beat(1'b1, 1'b0, 2);
        beat(1'b1, 1'b0, 2);
        beat(1'b0, 1'b1, 2);
        chk("proto_err_set", 32'(perr), 1);
        chk("err_cnt_two", 32'(ecnt), ERRC ? 32'd2 : 32'd0);
        wait_done();
        rd3("err_flow", 2, 24, 44, 2);

        // Reset in the middle of a packet
        beat(1'b1, 1'b0, 6);
        rst_n = 1'b0;
        #1;
        chk("rst_rd_l2", rd_l2, 0);
        chk("rst_rd_l1", rd_l1, 0);
        chk("rst_proto_err", 32'(perr), 0);
        chk("rst_err_cnt", 32'(ecnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(1'b0, 1'b1, 6);
        chk("rst_fsm_idle_err", 32'(perr), 1);
        chk("rst_err_cnt_one", 32'(ecnt), ERRC ? 32'd1 : 32'd0);
        wait_done();
        rd3("rst_flow6", 6, 0, 0, 0);

        // Clear coinciding with the window end
        wait_done();
        send_pkt(4, 64);
        wait_done();
        rd3("pre_clear", 4, 64, 84, 1);
        send_pkt(4, 64);
        repeat (990) @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("clear_no_done", 32'(done), 0);
        chk("clear_rd_l2", rd_l2, 0);
        chk("clear_rd_pkts", rd_pk, 0);
        chk("clear_keeps_err", 32'(perr), 1);
        chk("clear_err_cnt", 32'(ecnt), 0);
        rd3("clear_flow4", 4, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_flow_stat.md
Name: pkt_flow_stat

Overview:
- Synthesizable per-flow traffic meter; sits directly downstream of the packet generator output bus (data/sop/eop/empty/val/flow_num).
- Accumulates per-flow L1 bytes, L2 bytes and packet counts over a fixed measurement window.
- Snapshots the totals at each window end and exposes them through a registered read port, so hardware can check per-flow rates.
- Flags bus framing errors.

Parameters:
- D_WIDTH, 64, bus data width in bits; D_WIDTH/8 bytes per beat.
- EMPTY_WIDTH, 3, width of empty; must satisfy 2**EMPTY_WIDTH == D_WIDTH/8.
- FLOW_CNT, 16, number of flows tracked.
- FLOW_W, 4, flow index width, $clog2(FLOW_CNT).
- WINDOW_TICKS, 156250, window length in clk cycles (1 ms at 156.25 MHz); must be at least 2.
- CNT_W, 32, width of every byte and packet counter.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- sop_i, input, 1, start of packet, qualified by val_i.
- eop_i, input, 1, end of packet, qualified by val_i.
- empty_i, input, EMPTY_WIDTH, unused bytes in the eop beat.
- val_i, input, 1, beat valid.
- flow_num_i, input, FLOW_W, flow index, sampled on the sop beat.
- clear_i, input, 1, synchronous clear of accumulators, snapshots and window counter.
- rd_flow_i, input, FLOW_W, snapshot read index.
- rd_l1_bytes_o, output, CNT_W, snapshot L1 bytes of rd_flow_i.
- rd_l2_bytes_o, output, CNT_W, snapshot L2 bytes of rd_flow_i.
- rd_pkts_o, output, CNT_W, snapshot packet count of rd_flow_i.
- window_done_o, output, 1, one-cycle pulse when a new snapshot is valid.
- proto_err_o, output, 1, sticky framing-error flag.
- err_cnt_o, output, 16, framing-error count (optional feature).

Behaviour:
- Reset (rst_n low, asynchronous): all accumulators, snapshots, rd_* outputs, window counter, window_done_o, proto_err_o and err_cnt_o are 0; FSM goes to IDLE.
- Beat bytes: L2 = D_WIDTH/8 on non-eop beats, D_WIDTH/8 - empty_i on the eop beat; L1 = L2, plus 20 on the eop beat (12 IFG + 8 preamble). empty_i is ignored when eop_i is 0.
- Framing FSM:
  - IDLE: val&sop&!eop -> IN_PKT, latch flow_num_i. val&sop&eop -> single-beat packet, stay IDLE. val&!sop -> error, beat discarded, stay IDLE.
  - IN_PKT: val&!sop&eop -> IDLE. val&sop -> error; close the old packet (pkts+1, no +20) and start a new one with the new flow, counting the beat.
- Bytes are credited each valid accepted beat to the latched flow; on the sop beat, to flow_num_i. Packet count +1 on each eop beat.
- Window counter runs 0..WINDOW_TICKS-1 and wraps. On the cycle it equals WINDOW_TICKS-1:
  - accumulators plus that cycle's contribution are copied to the snapshots;
  - accumulators are zeroed;
  - window_done_o pulses on the next cycle.
- A packet spanning a window boundary is split: bytes go to the window containing each beat, and the packet counts in the window of its eop.
- Accumulators saturate at 2**CNT_W-1; no wrap.
- Read port: rd_* are registered and reflect the snapshot of rd_flow_i with 1-cycle latency. A read in the window_done_o cycle returns new data.
- clear_i: same effect as reset except proto_err_o holds; FSM goes to IDLE. clear_i overrides a coincident window end (no snapshot, no pulse).
- proto_err_o is set on any error and cleared only by reset.
- flow_num_i >= FLOW_CNT on sop: error, packet discarded; FSM still tracks framing.

Optional Feature:
- PKT_FLOW_STAT_ERR_CNT_EN defined: err_cnt_o counts framing errors, saturating at 16'hFFFF, cleared by reset and clear_i.
- Undefined: err_cnt_o tied to 0 and no counter logic is generated.

Test Plan:
- WINDOW_TICKS=1000, flow 3, one 64-byte packet (8 beats, empty 0) -> after window_done_o, read flow 3 gives L2=64, L1=84, pkts=1; all other flows read 0.
- Back-to-back 65-byte packets on flow 0 (9 beats, last empty 7), 50 packets in one window -> L2=3250, L1=4250, pkts=50.
- Packet whose beats straddle tick 999 -> beats split across the two snapshots; pkts counted only in the second window.
- val without sop in IDLE, then sop during IN_PKT -> proto_err_o=1, stray beat not counted, err_cnt_o=2 with the macro defined (0 without).
- CNT_W=8, 300 bytes in a window -> rd_l2_bytes_o=255.
- clear_i asserted at tick 999 -> no window_done_o, snapshots 0; rst_n low mid-packet -> all outputs 0 and FSM in IDLE.
